// File: rtl/mtr_pwm_drv.sv
// Dual-wheel H-bridge PWM driver: period-latched duty, dead-time lead-in, coast period on reversal.
// Optional feature: define MTR_SLEW_LIMIT_EN to rate-limit latched duty by SLEW_STEP per period.
module mtr_pwm_drv #(
    parameter int PWM_W     = 11,
    parameter int DEADTIME  = 16,
    parameter int SLEW_STEP = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pwr_up,
    input  logic [11:0] lft_spd,
    input  logic [11:0] rght_spd,
    output logic        PWM_frwrd_lft,
    output logic        PWM_rev_lft,
    output logic        PWM_frwrd_rght,
    output logic        PWM_rev_rght,
    output logic        prd_strt
);

    localparam int               MAG_MAX = 2**PWM_W - 1;
    localparam logic [11:0]      MAG_LIM = 12'(MAG_MAX);
    localparam logic [PWM_W-1:0] CNT_MAX = '1;
    localparam logic [PWM_W-1:0] DT      = DEADTIME[PWM_W-1:0];
`ifdef MTR_SLEW_LIMIT_EN
    localparam logic [PWM_W-1:0] STEP    = SLEW_STEP[PWM_W-1:0];
`endif

    typedef struct packed {
        logic [PWM_W-1:0] duty;
        logic             dir;       // 0 forward, 1 reverse
        logic             coast;
        logic             rev_pend;  // ramping down ahead of a reversal
    } wheel_t;

    logic [PWM_W-1:0] cnt;
    logic [11:0]      spd [2];
    wheel_t           whl [2];
    wheel_t           nxt [2];
    logic [1:0]       drv;
    logic [1:0]       frwrd;
    logic [1:0]       rev;

    assign spd[0] = lft_spd;
    assign spd[1] = rght_spd;

    function automatic logic [PWM_W-1:0] sat_mag(input logic [11:0] s);
        logic [11:0] a;
        a = s[11] ? (~s + 12'd1) : s;
        return (a > MAG_LIM) ? MAG_LIM[PWM_W-1:0] : a[PWM_W-1:0];
    endfunction

    function automatic wheel_t next_wheel(input wheel_t cur, input logic [11:0] s, input logic en);
        wheel_t           n;
        logic [PWM_W-1:0] tgt;
        logic             tdir;
        tgt  = en ? sat_mag(s) : '0;
        tdir = en ? s[11] : cur.dir;
        n    = cur;
`ifdef MTR_SLEW_LIMIT_EN
        n.coast = 1'b0;
        if (tdir != cur.dir && cur.duty != '0) begin
            n.duty     = (cur.duty > STEP) ? cur.duty - STEP : '0;
            n.rev_pend = 1'b1;
        end else if (tdir != cur.dir) begin
            // Duty has reached zero: flip direction, spend one period coasting, then ramp.
            n.dir      = tdir;
            n.coast    = cur.rev_pend;
            n.rev_pend = 1'b0;
            n.duty     = cur.rev_pend ? '0 : ((tgt > STEP) ? STEP : tgt);
        end else begin
            n.rev_pend = 1'b0;
            if (tgt > cur.duty)
                n.duty = (tgt - cur.duty > STEP) ? cur.duty + STEP : tgt;
            else
                n.duty = (cur.duty - tgt > STEP) ? cur.duty - STEP : tgt;
        end
`else
        n.duty     = tgt;
        n.dir      = tdir;
        n.coast    = (tdir != cur.dir) && (cur.duty != '0);
        n.rev_pend = 1'b0;
`endif
        return n;
    endfunction

    // NOTE: every variable written here gets a value on every path, so no latch is inferred.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            nxt[i] = next_wheel(whl[i], spd[i], pwr_up);
            drv[i] = pwr_up & ~whl[i].coast & (cnt >= DT) & (cnt < whl[i].duty);
        end
    end

    // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            prd_strt <= 1'b0;
            frwrd    <= '0;
            rev      <= '0;
            for (int i = 0; i < 2; i++) whl[i] <= '0;
        end else begin
            cnt      <= cnt + 1'b1;
            prd_strt <= (cnt == '0);
            for (int i = 0; i < 2; i++) begin
                if (cnt == CNT_MAX) whl[i] <= nxt[i];
                frwrd[i] <= drv[i] & ~whl[i].dir;
                rev[i]   <= drv[i] &  whl[i].dir;
            end
        end
    end

    assign PWM_frwrd_lft  = frwrd[0];
    assign PWM_rev_lft    = rev[0];
    assign PWM_frwrd_rght = frwrd[1];
    assign PWM_rev_rght   = rev[1];

endmodule

// File: tb/tb_mtr_pwm_drv.sv
// Testbench for mtr_pwm_drv: per-period pulse counts from a vector table, plus pwr_up/rst sequences.
module tb_mtr_pwm_drv;

    logic        clk = 1'b0;
    logic        rst;
    logic        pwr_up;
    logic [11:0] lft_spd;
    logic [11:0] rght_spd;
    logic        PWM_frwrd_lft, PWM_rev_lft, PWM_frwrd_rght, PWM_rev_rght, prd_strt;

    mtr_pwm_drv dut (
        .clk            (clk),
        .rst            (rst),
        .pwr_up         (pwr_up),
        .lft_spd        (lft_spd),
        .rght_spd       (rght_spd),
        .PWM_frwrd_lft  (PWM_frwrd_lft),
        .PWM_rev_lft    (PWM_rev_lft),
        .PWM_frwrd_rght (PWM_frwrd_rght),
        .PWM_rev_rght   (PWM_rev_rght),
        .prd_strt       (prd_strt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] lft;
        logic [11:0] rght;
        logic        pwr;
        int          fl, rl, fr, rr;  // expected high clocks per period
    } vec_t;

    vec_t vecs [12];
    vec_t sb_q [$];
    vec_t exp_v;
    int   n_vec  = 0;
    int   n_miss = 0;
    int   fl, rl, fr, rr, ps, ovl, k;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Returns on the negedge where prd_strt is high (counter value 1).
    task automatic wait_prd(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!prd_strt && cycles < 4200);
        if (!prd_strt) check("prd_strt_timeout", 0, 1);
    endtask

    // Samples one full period starting at the current negedge.
    task automatic measure(output int m_fl, output int m_rl, output int m_fr,
                           output int m_rr, output int m_ps, output int m_ovl);
        m_fl = 0; m_rl = 0; m_fr = 0; m_rr = 0; m_ps = 0; m_ovl = 0;
        for (int i = 0; i < 2048; i++) begin
            if (i > 0) @(negedge clk);
            m_fl  += int'(PWM_frwrd_lft);
            m_rl  += int'(PWM_rev_lft);
            m_fr  += int'(PWM_frwrd_rght);
            m_rr  += int'(PWM_rev_rght);
            m_ps  += int'(prd_strt);
            m_ovl += int'((PWM_frwrd_lft & PWM_rev_lft) | (PWM_frwrd_rght & PWM_rev_rght));
        end
    endtask

    initial begin
        // lft, rght, pwr, fwd_lft, rev_lft, fwd_rght, rev_rght
        vecs[0]  = '{12'h000, 12'h000, 1'b1,   0,   0,    0,    0};
        vecs[1]  = '{12'h200, 12'h800, 1'b1, 496,   0,    0, 2031};
        vecs[2]  = '{12'hE00, 12'h800, 1'b1,   0,   0,    0, 2031};  // left coasts
        vecs[3]  = '{12'hE00, 12'h001, 1'b1,   0, 496,    0,    0};  // right coasts
        vecs[4]  = '{12'hE00, 12'h001, 1'b1,   0, 496,    0,    0};  // duty 1: no pulse
        vecs[5]  = '{12'h00A, 12'h7FF, 1'b1,   0,   0, 2031,    0};  // left coasts
        vecs[6]  = '{12'h00A, 12'h7FF, 1'b1,   0,   0, 2031,    0};  // duty 10 < dead time
        vecs[7]  = '{12'h011, 12'h011, 1'b1,   1,   0,    1,    0};
        vecs[8]  = '{12'h010, 12'h010, 1'b1,   0,   0,    0,    0};
        vecs[9]  = '{12'h200, 12'h200, 1'b0,   0,   0,    0,    0};
        vecs[10] = '{12'h200, 12'hE00, 1'b1, 496,   0,    0,  496};  // prior duty 0: no coast
        vecs[11] = '{12'hFFF, 12'h801, 1'b1,   0,   0,    0, 2031};

        rst = 1'b1; pwr_up = 1'b0; lft_spd = '0; rght_spd = '0;
        repeat (3) @(negedge clk);
        check("rst_fwd_lft",  int'(PWM_frwrd_lft),  0);
        check("rst_rev_rght", int'(PWM_rev_rght),   0);
        check("rst_prd_strt", int'(prd_strt),       0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            wait_prd(k);
            lft_spd = vecs[i].lft; rght_spd = vecs[i].rght; pwr_up = vecs[i].pwr;
            sb_q.push_back(vecs[i]);
            wait_prd(k);
            measure(fl, rl, fr, rr, ps, ovl);
            exp_v = sb_q.pop_front();
            check($sformatf("v%0d_fwd_lft", i),  fl,  exp_v.fl);
            check($sformatf("v%0d_rev_lft", i),  rl,  exp_v.rl);
            check($sformatf("v%0d_fwd_rght", i), fr,  exp_v.fr);
            check($sformatf("v%0d_rev_rght", i), rr,  exp_v.rr);
            check($sformatf("v%0d_prd_strt", i), ps,  1);
            check($sformatf("v%0d_overlap", i),  ovl, 0);
        end

        wait_prd(k);
        wait_prd(k);
        check("prd_period", k, 2048);

        // pwr_up drop at cnt=100 with duty 512 in effect
        wait_prd(k);
        lft_spd = 12'h200; rght_spd = 12'h000; pwr_up = 1'b1;
        wait_prd(k);
        wait_prd(k);
        repeat (99) @(negedge clk);
        check("pre_drop_fwd_lft", int'(PWM_frwrd_lft), 1);
        pwr_up = 1'b0;
        @(negedge clk);
        check("pwr_drop_fwd_lft", int'(PWM_frwrd_lft), 0);
        pwr_up = 1'b1;

        // async reset mid-pulse
        wait_prd(k);
        repeat (199) @(negedge clk);
        check("pre_rst_fwd_lft", int'(PWM_frwrd_lft), 1);
        rst = 1'b1;
        #1;
        check("rst_async_fwd_lft", int'(PWM_frwrd_lft), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("restart_prd_strt", int'(prd_strt), 1);
        measure(fl, rl, fr, rr, ps, ovl);
        check("restart_duty0_fwd_lft", fl, 0);
        wait_prd(k);
        measure(fl, rl, fr, rr, ps, ovl);
        check("post_rst_fwd_lft", fl, 496);
        check("post_rst_rev_lft", rl, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
